gearbox_32_24: RTL and testbench



---
 rtl/gearbox_32_24.sv | 99 +++++++++
 tb/tb_gearbox_32_24.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/gearbox_32_24.sv
// gearbox_32_24: repacks a stream of 32-bit words into 24-bit pixels,
// least-significant byte first. A 64-bit byte buffer absorbs the 4:3 rate
// mismatch, and data_in_ready throttles the source whenever the buffer
// might overflow. An end-of-frame word triggers a flush. The flush emits
// the residual bytes zero-padded and tags the final pixel.
module gearbox_32_24 (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        data_en,
    input  logic        data_in_last,
    output logic        data_in_ready,
    output logic [23:0] data_out,
    output logic        data_out_en,
    output logic        data_out_last
);

    logic [63:0] byteBuf_q, byteBuf_d;
    logic [3:0]  fill_q, fill_d;
    logic        flushing_q, flushing_d;
    logic [23:0] dataOut_q, dataOut_d;
    logic        outEn_q, outEn_d;
    logic        outLast_q, outLast_d;

    logic        transfer;
    logic [3:0]  fillAfterEmit;
    logic [63:0] bufAfterEmit;

    // A flush locks out the source until the last pixel leaves. The fill
    // bound of 7 keeps fill at or below 8 after a combined emit and append.
    assign data_in_ready = !flushing_q && (fill_q <= 4'd7);
    assign transfer      = data_en && data_in_ready;

    assign data_out      = dataOut_q;
    assign data_out_en   = outEn_q;
    assign data_out_last = outLast_q;

    // Decide this cycle's emit from the registered fill, then append any accepted word above what remains
    always_comb begin
        dataOut_d     = dataOut_q;
        outEn_d       = 1'b0;
        outLast_d     = 1'b0;
        fillAfterEmit = fill_q;
        bufAfterEmit  = byteBuf_q;
        flushing_d    = flushing_q;
        fill_d        = fill_q;
        byteBuf_d     = byteBuf_q;

        if (fill_q >= 4'd3) begin
            dataOut_d     = byteBuf_q[23:0];
            outEn_d       = 1'b1;
            fillAfterEmit = fill_q - 4'd3;
            bufAfterEmit  = byteBuf_q >> 24;
        end else if (flushing_q && (fill_q != 4'd0)) begin
            dataOut_d     = (fill_q == 4'd1) ? {16'h0000, byteBuf_q[7:0]}
                                             : {8'h00, byteBuf_q[15:0]};
            outEn_d       = 1'b1;
            fillAfterEmit = 4'd0;
            bufAfterEmit  = 64'd0;
        end

        outLast_d = outEn_d && flushing_q && (fillAfterEmit == 4'd0);

        if (outLast_d) begin
            flushing_d = 1'b0;
        end
        if (transfer && data_in_last) begin
            flushing_d = 1'b1;
        end

        if (transfer) begin
            fill_d    = fillAfterEmit + 4'd4;
            byteBuf_d = bufAfterEmit | ({32'd0, data_in} << {fillAfterEmit, 3'b000});
        end else begin
            fill_d    = fillAfterEmit;
            byteBuf_d = bufAfterEmit;
        end
    end

    // Register buffer, fill, flush state and outputs; reset discards any partial frame
    always_ff @(posedge clk_in) begin
        if (reset) begin
            byteBuf_q  <= 64'd0;
            fill_q     <= 4'd0;
            flushing_q <= 1'b0;
            dataOut_q  <= 24'd0;
            outEn_q    <= 1'b0;
            outLast_q  <= 1'b0;
        end else begin
            byteBuf_q  <= byteBuf_d;
            fill_q     <= fill_d;
            flushing_q <= flushing_d;
            dataOut_q  <= dataOut_d;
            outEn_q    <= outEn_d;
            outLast_q  <= outLast_d;
        end
    end

endmodule

// File: tb/tb_gearbox_32_24.sv
// tb_gearbox_32_24: scoreboard bench for the 32-to-24 gearbox. Expected
// pixels are built from each frame's input bytes and queued. A monitor pops
// them as the DUT emits.
module tb_gearbox_32_24;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        data_en;
    logic        data_in_last;
    logic        data_in_ready;
    logic [23:0] data_out;
    logic        data_out_en;
    logic        data_out_last;

    typedef struct packed {
        logic [23:0] data;
        logic        last;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monExp;
    logic [31:0] frameWords[32];
    int          checks = 0;
    int          failures = 0;
    int          maxFill = 0;
    int          stallCount = 0;
    int          gapCount = 0;
    bit          trackGaps = 0;
    bit          seenFirst = 0;

    gearbox_32_24 dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .data_in       (data_in),
        .data_en       (data_en),
        .data_in_last  (data_in_last),
        .data_in_ready (data_in_ready),
        .data_out      (data_out),
        .data_out_en   (data_out_en),
        .data_out_last (data_out_last)
    );

    // Free-running clock
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Byte-level reference: flatten the frame LSB-first and cut it into 3-byte pixels
    task automatic buildExpected(input int n);
        logic [7:0]  bytes[$];
        logic [23:0] acc;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                bytes.push_back(frameWords[i][8*b +: 8]);
            end
        end
        while (bytes.size() > 0) begin
            acc = 24'd0;
            for (int b = 0; b < 3; b++) begin
                if (bytes.size() > 0) acc[8*b +: 8] = bytes.pop_front();
            end
            expQ.push_back('{data: acc, last: (bytes.size() == 0)});
        end
    endtask

    // Offer words at negedges and hold them until the DUT is ready; optional random idle gaps
    task automatic applyStimulus(input int n, input bit withLast, input bit withGaps);
        int wait_cnt;
        for (int i = 0; i < n; i++) begin
            if (withGaps) begin
                int idle = $urandom_range(0, 2);
                for (int g = 0; g < idle; g++) begin
                    @(negedge clk_in);
                    data_en = 1'b0;
                end
            end
            @(negedge clk_in);
            data_in      = frameWords[i];
            data_en      = 1'b1;
            data_in_last = withLast && (i == n - 1);
            wait_cnt = 0;
            while (!data_in_ready && wait_cnt < 100) begin
                @(negedge clk_in);
                wait_cnt++;
                stallCount++;
            end
            if (wait_cnt >= 100) checkOutput("readyTimeout", {31'd0, data_in_ready}, 32'd1);
            @(posedge clk_in);
        end
        @(negedge clk_in);
        data_en      = 1'b0;
        data_in_last = 1'b0;
    endtask

    // Wait for every queued pixel to appear, then confirm the source is released
    task automatic waitDrain(input string tag);
        int cnt = 0;
        while (expQ.size() > 0 && cnt < 500) begin
            @(negedge clk_in);
            cnt++;
        end
        checkOutput({tag, "_drained"}, expQ.size(), 32'd0);
        repeat (2) @(negedge clk_in);
        checkOutput({tag, "_readyBack"}, {31'd0, data_in_ready}, 32'd1);
    endtask

    // Monitor: compare every emitted pixel against the scoreboard and track fill and output gaps
    always @(negedge clk_in) begin
        if (int'(dut.fill_q) > maxFill) maxFill = int'(dut.fill_q);
        if (data_out_last && !data_out_en) checkOutput("lastWithoutEn", {31'd0, data_out_last}, 32'd0);
        if (data_out_en) begin
            if (expQ.size() == 0) begin
                checkOutput("spuriousEn", {31'd0, data_out_en}, 32'd0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("outData", {8'd0, data_out}, {8'd0, monExp.data});
                checkOutput("outLast", {31'd0, data_out_last}, {31'd0, monExp.last});
            end
        end
        if (trackGaps) begin
            if (data_out_en) seenFirst = 1'b1;
            else if (seenFirst && expQ.size() > 0) gapCount++;
        end
    end

    initial begin
        reset        = 1'b1;
        data_in      = 32'd0;
        data_en      = 1'b0;
        data_in_last = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        checkOutput("rstData", {8'd0, data_out}, 32'd0);
        checkOutput("rstEn", {31'd0, data_out_en}, 32'd0);
        checkOutput("rstLast", {31'd0, data_out_last}, 32'd0);
        checkOutput("rstReady", {31'd0, data_in_ready}, 32'd1);
        reset = 1'b0;

        // Three-word frame: exact fit, no padding
        frameWords[0] = 32'h03020100;
        frameWords[1] = 32'h07060504;
        frameWords[2] = 32'h0B0A0908;
        buildExpected(3);
        applyStimulus(3, 1'b1, 1'b0);
        waitDrain("three");

        // Two-word frame: final pixel carries one pad byte
        frameWords[0] = 32'h03020100;
        frameWords[1] = 32'h07060504;
        buildExpected(2);
        applyStimulus(2, 1'b1, 1'b0);
        waitDrain("two");

        // Single-word frame: source must be blocked during the flush
        frameWords[0] = 32'hDDCCBBAA;
        buildExpected(1);
        applyStimulus(1, 1'b1, 1'b0);
        checkOutput("singleReadyLow", {31'd0, data_in_ready}, 32'd0);
        waitDrain("single");

        // Continuous stream of 12 words with incrementing bytes
        for (int i = 0; i < 12; i++) begin
            for (int b = 0; b < 4; b++) frameWords[i][8*b +: 8] = 8'(4*i + b + 16);
        end
        buildExpected(12);
        checkOutput("contExpCount", expQ.size(), 32'd16);
        stallCount = 0;
        gapCount   = 0;
        seenFirst  = 1'b0;
        trackGaps  = 1'b1;
        applyStimulus(12, 1'b1, 1'b0);
        checkOutput("contStalls", stallCount, 32'd3);
        waitDrain("cont");
        trackGaps = 1'b0;
        checkOutput("contGaps", gapCount, 32'd0);

        // Random data with idle gaps and backpressure
        for (int i = 0; i < 9; i++) frameWords[i] = $urandom;
        buildExpected(9);
        applyStimulus(9, 1'b1, 1'b1);
        waitDrain("rand");

        // Reset mid-frame after two words; only the pixel already registered escapes
        frameWords[0] = 32'hA3A2A1A0;
        frameWords[1] = 32'hA7A6A5A4;
        expQ.push_back('{data: 24'hA2A1A0, last: 1'b0});
        applyStimulus(2, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        checkOutput("abortData", {8'd0, data_out}, 32'd0);
        checkOutput("abortEn", {31'd0, data_out_en}, 32'd0);
        checkOutput("abortLast", {31'd0, data_out_last}, 32'd0);
        checkOutput("abortReady", {31'd0, data_in_ready}, 32'd1);
        checkOutput("abortQueue", expQ.size(), 32'd0);
        reset = 1'b0;
        frameWords[0] = 32'h03020100;
        buildExpected(1);
        applyStimulus(1, 1'b1, 1'b0);
        waitDrain("postAbort");

        checkOutput("fillMax", maxFill, 32'd8);
        repeat (3) @(negedge clk_in);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
